// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin front end for one shared, free-running FPU.
// The FPU has no handshake, so the winner's operands are held for FPU_WAIT
// cycles and then the result/status are captured into a tagged response
// register with valid/ready back-pressure.
// Optional build macro FPU_SHARE_ARBITER_SUB_EN adds req_sub; a set bit flips
// the sign of operand B on accept so the shared FPU computes A-B.
module fpu_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int FPU_WAIT = 64,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                    clock_100Khz,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_op_a,
  input  logic [NUM_REQ*32-1:0]   req_op_b,
`ifdef FPU_SHARE_ARBITER_SUB_EN
  input  logic [NUM_REQ-1:0]      req_sub,
`endif
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_data,
  output logic [3:0]              rsp_status,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             fpu_op_a,
  output logic [31:0]             fpu_op_b,
  input  logic [31:0]             fpu_data_in,
  input  logic [3:0]              fpu_status_in,
  output logic                    busy
);

  localparam int CNT_W = (FPU_WAIT > 1) ? $clog2(FPU_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FPU_WAIT - 1);
  localparam logic [3:0] ST_EXACT = 4'd2;

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [3:0]        rsp_status_q, rsp_status_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;

  logic              found;
  logic [ID_W-1:0]   winner;
  logic [NUM_REQ-1:0] grant;
  logic [31:0]       sel_a, sel_b;

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin : arb
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
    grant = found ? (NUM_REQ'(1) << winner) : '0;
  end

  // Operand mux for the current winner, with optional sign flip of B.
  always_comb begin
    sel_a = req_op_a[32*int'(winner) +: 32];
    sel_b = req_op_b[32*int'(winner) +: 32];
`ifdef FPU_SHARE_ARBITER_SUB_EN
    if (req_sub[winner]) sel_b[31] = ~sel_b[31];
`endif
  end

  // Next-state and output logic of the IDLE/WAIT/RESPOND controller.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    wait_cnt_d   = wait_cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    rsp_id_d     = rsp_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    req_ready    = '0;
    unique case (state_q)
      IDLE: begin
        if (!reset) req_ready = grant;
        // grant is only raised on a valid bit, so a grant is an accept
        if (found) begin
          op_a_d     = sel_a;
          op_b_d     = sel_b;
          rsp_id_d   = winner;
          rr_ptr_d   = ID_W'((int'(winner) + 1) % NUM_REQ);
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == CNT_LAST) begin
          rsp_data_d   = fpu_data_in;
          rsp_status_d = fpu_status_in;
          rsp_valid_d  = 1'b1;
          state_d      = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge clock_100Khz) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      wait_cnt_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_EXACT;
      rsp_id_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      wait_cnt_q   <= wait_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      rsp_id_q     <= rsp_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign rsp_id     = rsp_id_q;
  assign fpu_op_a   = op_a_q;
  assign fpu_op_b   = op_b_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: random requesters plus directed phases,
// a transaction-level model with a response scoreboard, and an FPU stub.
module tb_fpu_share_arbiter;
  localparam int NREQ = 4;
  localparam int FW   = 64;
  localparam int IDW  = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_op_a, req_op_b;
  logic [NREQ-1:0]     req_sub;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid, rsp_ready;
  logic [31:0]         rsp_data;
  logic [3:0]          rsp_status;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         fpu_op_a, fpu_op_b, fpu_data_in;
  logic [3:0]          fpu_status_in;
  logic                busy;

  logic [31:0] opa [NREQ];
  logic [31:0] opb [NREQ];

  always #5 clk = ~clk;

  fpu_share_arbiter #(.NUM_REQ(NREQ), .FPU_WAIT(FW)) dut (
    .clock_100Khz(clk), .reset(reset), .req_valid(req_valid),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
`ifdef FPU_SHARE_ARBITER_SUB_EN
    .req_sub(req_sub),
`endif
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status), .rsp_id(rsp_id),
    .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_data_in(fpu_data_in),
    .fpu_status_in(fpu_status_in), .busy(busy)
  );

  always_comb
    for (int i = 0; i < NREQ; i++) begin
      req_op_a[32*i +: 32] = opa[i];
      req_op_b[32*i +: 32] = opb[i];
    end

  // FPU stub: 1.0 + 1.0 gives 2.0/EXACT, anything else a cheap mix of inputs.
  function automatic logic [35:0] fpu_fn(logic [31:0] a, logic [31:0] b);
    if (a == 32'h3FE00000 && b == 32'h3FE00000) return {4'd2, 32'h40000000};
    return {a[3:0] ^ b[7:4], a + b};
  endfunction
  assign {fpu_status_in, fpu_data_in} = fpu_fn(fpu_op_a, fpu_op_b);

  function automatic logic [31:0] beff(logic [31:0] b, logic s);
`ifdef FPU_SHARE_ARBITER_SUB_EN
    return s ? {~b[31], b[30:0]} : b;
`else
    return s ? b : b;
`endif
  endfunction

  typedef struct {
    logic [31:0] a, b, data;
    logic [3:0]  st;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, done_cnt = 0;
  logic [NREQ-1:0] acc_mask = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: whenever the arbiter is free, the next grant goes to the
  // first valid requester at or after m_rr; the response appears FW edges
  // after the accept edge and lives until an edge with rsp_ready high.
  bit   m_busy = 0, rst_prev = 0;
  int   m_rr = 0, acc_cyc = 0;
  always @(negedge clk) begin : monitor
    logic [NREQ-1:0] exp_rdy;
    bit   fnd, exp_v;
    int   w, idx;
    exp_t e;
    if (rst_prev) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_status", rsp_status, 2);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fpu_op_a", fpu_op_a, 0);
      chk("rst_fpu_op_b", fpu_op_b, 0);
    end
    rst_prev = reset;
    acc_mask = req_valid & req_ready;
    if (reset) begin
      chk("rst_req_ready", req_ready, 0);
      m_busy = 0; m_rr = 0; sb.delete();
    end else begin
      exp_rdy = '0; fnd = 0; w = 0;
      if (!m_busy)
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_rr + k) % NREQ;
          if (!fnd && req_valid[idx]) begin fnd = 1; w = idx; end
        end
      if (fnd) exp_rdy[w] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, m_busy);
      if (m_busy && sb.size() > 0) begin
        e = sb[0];
        chk("fpu_op_a", fpu_op_a, e.a);
        chk("fpu_op_b", fpu_op_b, e.b);
        exp_v = (cyc - acc_cyc) >= FW;
        chk("rsp_valid", rsp_valid, exp_v);
        if (exp_v) begin
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_status", rsp_status, e.st);
          chk("rsp_id", rsp_id, e.id);
          if (rsp_ready) begin
            void'(sb.pop_front());
            m_busy = 0;
            done_cnt++;
          end
        end
      end else begin
        chk("rsp_valid_idle", rsp_valid, 0);
      end
      if (fnd) begin
        e.a = opa[w];
        e.b = beff(opb[w], req_sub[w]);
        {e.st, e.data} = fpu_fn(e.a, e.b);
        e.id = w;
        sb.push_back(e);
        m_busy = 1; acc_cyc = cyc + 1;
        m_rr = (w + 1) % NREQ;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    req_valid = req_valid & ~acc_mask;
  endtask

  task automatic raise(int i, logic [31:0] a, logic [31:0] b, logic s);
    opa[i] = a; opb[i] = b; req_sub[i] = s; req_valid[i] = 1'b1;
  endtask

  task automatic wait_done(int target, string name);
    for (int t = 0; t < 2000 && done_cnt < target; t++) tick();
    chk(name, done_cnt, target);
  endtask

  initial begin
    int base;
    reset = 1; req_valid = '0; req_sub = '0; rsp_ready = 0;
    for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
    repeat (4) tick();
    reset = 0;

    // single 1.0 + 1.0 request from requester 0
    raise(0, 32'h3FE00000, 32'h3FE00000, 1'b0);
    rsp_ready = 1;
    wait_done(1, "single_done");

    // all requesters continuously valid: rotating grants
    base = done_cnt;
    for (int t = 0; t < 2000 && done_cnt < base + 6; t++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i]) raise(i, $urandom, $urandom, 1'b0);
      tick();
    end
    chk("rr_done", done_cnt, base + 6);
    req_valid = '0;
    tick();

    // back-pressure with a subtract request on requester 2
    rsp_ready = 0;
    raise(2, 32'h12345678, 32'h3FE00000, 1'b1);
    for (int t = 0; t < 200 && !rsp_valid; t++) tick();
    chk("bp_rsp_seen", rsp_valid, 1);
    raise(0, $urandom, $urandom, 1'b0);
    repeat (10) tick();
    base = done_cnt;
    rsp_ready = 1;
    wait_done(base + 1, "bp_done");
    req_valid = '0;
    raise(2, 32'h12345678, 32'h3FE00000, 1'b0);
    wait_done(base + 2, "nosub_done");

    // reset in the middle of WAIT, with rr pointer away from 0
    raise(1, $urandom, $urandom, 1'b0);
    for (int t = 0; t < 200 && !(acc_mask[1]); t++) tick();
    repeat (20) tick();
    reset = 1; tick(); reset = 0;
    base = done_cnt;
    for (int i = 0; i < NREQ; i++) raise(i, $urandom, $urandom, 1'($urandom));
    wait_done(base + 1, "post_rst_done");
    req_valid = '0;
    tick();

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 5) == 0)
          raise(i, $urandom, $urandom, 1'($urandom));
        else if (req_valid[i] && !acc_mask[i] && $urandom_range(0, 49) == 0)
          req_valid[i] = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // drain
    req_valid = '0; rsp_ready = 1;
    for (int t = 0; t < 200 && m_busy; t++) tick();
    chk("drain_empty", sb.size(), 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_share_arbiter.md
Name: fpu_share_arbiter

Overview:
- Shares one FPU instance (32-bit format: sign[31], exp[30:21] bias 511, mant[20:0]) among NUM_REQ requesters.
- Round-robin arbitration. Winner's operands are held stable on the FPU inputs for a fixed settle window, then the FPU result and status are captured.
- The captured result is returned on a single tagged response channel with valid/ready back-pressure.
- Sits between client blocks and the free-running FPU, which has no start/done handshake of its own.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- FPU_WAIT, 64, cycles operands are held before the FPU result is sampled; must be ≥2 and cover two full FPU passes.
- ID_W, $clog2(NUM_REQ), width of the requester tag.

Ports:
- clock_100Khz  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_op_a  in  NUM_REQ*32  operand A, requester i at [32*i+31:32*i].
- req_op_b  in  NUM_REQ*32  operand B, same packing.
- req_ready  out  NUM_REQ  one-hot grant/accept; combinational.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  32  captured FPU result.
- rsp_status  out  4  captured FPU status (OVERFLOW=0, UNDERFLOW=1, EXACT=2, INEXACT=3).
- rsp_id  out  ID_W  index of the requester that owns the response.
- fpu_op_a  out  32  drives FPU Op_A_in.
- fpu_op_b  out  32  drives FPU Op_B_in.
- fpu_data_in  in  32  from FPU data_out.
- fpu_status_in  in  4  from FPU status_out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (synchronous, on any cycle with reset=1):
  - state IDLE, rr_ptr 0, wait_cnt 0.
  - rsp_valid 0, rsp_data 0, rsp_status 2 (EXACT), rsp_id 0.
  - fpu_op_a 0, fpu_op_b 0, busy 0.
  - req_ready 0 while reset is high.
- States: IDLE, WAIT, RESPOND.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0.
  - No valid request: stay in IDLE, req_ready all 0.
  - On accept (req_valid[w] & req_ready[w] at an edge):
    - fpu_op_a/fpu_op_b ← operands of w; rsp_id ← w.
    - rr_ptr ← (w+1) mod NUM_REQ; wait_cnt ← 0.
    - → WAIT.
- WAIT:
  - req_ready all 0.
  - fpu_op_a/b held constant; wait_cnt increments each cycle.
  - At the edge where wait_cnt == FPU_WAIT-1:
    - rsp_data ← fpu_data_in, rsp_status ← fpu_status_in, rsp_valid ← 1.
    - → RESPOND.
  - Latency: rsp_valid rises exactly FPU_WAIT cycles after the accept edge.
- RESPOND:
  - rsp_valid, rsp_data, rsp_status and rsp_id held stable; req_ready all 0.
  - On the edge with rsp_ready=1: rsp_valid ← 0, → IDLE.
  - Next accept is possible at the following edge. Minimum request-to-request spacing is FPU_WAIT+2 cycles.
- fpu_op_a/b keep their last value in IDLE; they are not cleared.
- A requester deasserting req_valid before it is accepted is legal; nothing is consumed.
- Operands must be stable while req_valid=1.
- rsp_ready high before rsp_valid has no effect.
- Reset mid-operation (WAIT or RESPOND): any in-flight result is discarded, rsp_valid never rises for it, and all reset values apply.
- rr_ptr only advances on an accept.

Optional Feature:
- Macro: FPU_SHARE_ARBITER_SUB_EN.
- Defined:
  - Adds input req_sub, NUM_REQ bits, sampled with the operands.
  - On accept, fpu_op_b ← {~op_b[31], op_b[30:0]} when req_sub[w]=1, so the shared FPU performs A−B.
- Undefined:
  - No req_sub port.
  - fpu_op_b is always the unmodified operand.

Test Plan:
- Reset check: hold reset high 3 cycles → rsp_valid=0, rsp_status=2, rsp_id=0, busy=0, fpu_op_a=fpu_op_b=0, req_ready=0.
- Single request:
  - Stimulus: req_valid[0] with A=0x3FE00000 (1.0), B=0x3FE00000; FPU stub drives 0x40000000/status 2.
  - Required: fpu_op_a=fpu_op_b=0x3FE00000 the cycle after accept.
  - Required: rsp_valid rises exactly 64 cycles after the accept edge, with rsp_data=0x40000000, rsp_status=2, rsp_id=0.
- Round robin: NUM_REQ=4, all req_valid held high, rsp_ready=1 → accept order 0,1,2,3,0,1.
- Back-pressure: rsp_ready=0 for 10 cycles during RESPOND → rsp_* stable, req_ready all 0, no accept; rsp_ready=1 → IDLE next cycle.
- Reset mid-WAIT: assert reset at wait_cnt=20 → IDLE next cycle, no rsp_valid for that request, next grant goes to requester 0.
- SUB_EN build: req_sub[2]=1 with B=0x3FE00000 → fpu_op_b=0xBFE00000; with req_sub[2]=0 → fpu_op_b=0x3FE00000.
